// File: rtl/mat_mult_pkg.sv
// mat_mult_pkg: shared result width, row-major indexing and N limits for the NxN matrix multiplier
package mat_mult_pkg;
  localparam int N_MIN = 2;
  localparam int N_MAX = 4;
  function automatic int ow_w(int dw, int n);
    return 2 * dw + $clog2(n);
  endfunction
  function automatic int idx(int i, int j, int n);
    return i * n + j;
  endfunction
endpackage

// File: rtl/mat_mult_nxn_pipe_if.sv
// mat_mult_nxn_pipe_if: operand handshake (start/in_ready/signed_mode/a_mat/b_mat) and result handshake (c_mat/done/out_ready)
interface mat_mult_nxn_pipe_if #(parameter int N = 2, parameter int DW = 16);
  localparam int OW = mat_mult_pkg::ow_w(DW, N);
  logic start;
  logic in_ready;
  logic signed_mode;
  logic [N*N*DW-1:0] a_mat;
  logic [N*N*DW-1:0] b_mat;
  logic [N*N*OW-1:0] c_mat;
  logic done;
  logic out_ready;
  modport master (output start, signed_mode, a_mat, b_mat, out_ready, input in_ready, c_mat, done);
  modport slave (input start, signed_mode, a_mat, b_mat, out_ready, output in_ready, c_mat, done);
endinterface

// File: rtl/mat_mult_dot.sv
// mat_mult_dot: one length-N dot product; products registered (S2), sum loaded into sum when ld (S3); en=0 holds all
module mat_mult_dot import mat_mult_pkg::*; #(
  parameter int N = 2,
  parameter int DW = 16,
  parameter int OW = ow_w(DW, N)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ld,
  input  logic sm,
  input  logic [N*DW-1:0] a,
  input  logic [N*DW-1:0] b,
  output logic [OW-1:0] sum
);
  logic signed [2*DW+1:0] p_n [N];
  logic signed [2*DW+1:0] p [N];
  logic [OW-1:0] s;
  for (genvar k = 0; k < N; k++) begin : g_k
    logic signed [DW:0] x, y;
    assign x = {sm & a[k*DW+DW-1], a[k*DW +: DW]};
    assign y = {sm & b[k*DW+DW-1], b[k*DW +: DW]};
    assign p_n[k] = x * y;
  end
  always_comb begin
    s = '0;
    for (int k = 0; k < N; k++) s = s + OW'(p[k]);
  end
  always_ff @(posedge clk) if (en) p <= p_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sum <= '0;
    else if (en && ld) sum <= s;
endmodule

// File: rtl/mat_mult_nxn_pipe.sv
// mat_mult_nxn_pipe: 3-stage pipelined C=AxB (clk, async active-low reset, bus: slave handshake of operands and results)
module mat_mult_nxn_pipe import mat_mult_pkg::*; #(
  parameter int N = 2,
  parameter int DW = 16
) (
  input logic clk,
  input logic reset,
  mat_mult_nxn_pipe_if.slave bus
);
  localparam int OW = ow_w(DW, N);
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("mat_mult_nxn_pipe: N out of range");
  end
  logic en, v1, v2, v3, sm1;
  logic [N*N*DW-1:0] a1, b1;
  logic [N*N*OW-1:0] c;
  assign en = ~(v3 & ~bus.out_ready);
  assign bus.in_ready = en;
  assign bus.done = v3;
  assign bus.c_mat = c;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {v1, v2, v3} <= '0;
    else if (en) {v1, v2, v3} <= {bus.start, v1, v2};
  always_ff @(posedge clk)
    if (en && bus.start) {a1, b1, sm1} <= {bus.a_mat, bus.b_mat, bus.signed_mode};
  for (genvar i = 0; i < N; i++) begin : g_i
    for (genvar j = 0; j < N; j++) begin : g_j
      logic [N*DW-1:0] ar, bc;
      for (genvar k = 0; k < N; k++) begin : g_k
        assign ar[k*DW +: DW] = a1[idx(i, k, N)*DW +: DW];
        assign bc[k*DW +: DW] = b1[idx(k, j, N)*DW +: DW];
      end
      mat_mult_dot #(.N(N), .DW(DW), .OW(OW)) u_dot (
        .clk(clk), .reset(reset), .en(en), .ld(v2), .sm(sm1),
        .a(ar), .b(bc), .sum(c[idx(i, j, N)*OW +: OW])
      );
    end
  end
endmodule

// File: tb/tb_mat_mult_nxn_pipe.sv
// tb_mat_mult_nxn_pipe: directed and streamed checks of the 2x2/16-bit and 3x3/8-bit multipliers
module tb_mat_mult_nxn_pipe;
  logic clk = 1'b0;
  logic reset;
  int vec = 0;
  int err = 0;
  int cyc, got_n, first_cyc, last_cyc, n_stall, n_acc;
  bit stall_prev, acc;
  logic [131:0] held;
  logic [131:0] expq[$];
  logic [63:0] a, b;
  mat_mult_nxn_pipe_if #(.N(2), .DW(16)) b2 ();
  mat_mult_nxn_pipe_if #(.N(3), .DW(8)) b3 ();
  mat_mult_nxn_pipe #(.N(2), .DW(16)) u2 (.clk(clk), .reset(reset), .bus(b2));
  mat_mult_nxn_pipe #(.N(3), .DW(8)) u3 (.clk(clk), .reset(reset), .bus(b3));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string t, input logic [131:0] got, input logic [131:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  task automatic chk_c(input string t, input longint e0, input longint e1, input longint e2, input longint e3);
    longint e[4];
    e = '{e0, e1, e2, e3};
    for (int q = 0; q < 4; q++) chk($sformatf("%s_c%0d", t, q), 132'(b2.c_mat[q*33 +: 33]), 132'(e[q][32:0]));
  endtask
  function automatic logic [63:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction
  function automatic logic [131:0] mm2(input logic [63:0] x, input logic [63:0] y, input bit sm);
    logic [131:0] r;
    longint s, u, v;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) begin
          u = sm ? longint'($signed(x[(i*2+k)*16 +: 16])) : longint'(x[(i*2+k)*16 +: 16]);
          v = sm ? longint'($signed(y[(k*2+j)*16 +: 16])) : longint'(y[(k*2+j)*16 +: 16]);
          s = s + u * v;
        end
        r[(i*2+j)*33 +: 33] = s[32:0];
      end
    return r;
  endfunction
  task automatic step(input bit st, input bit ordy, input logic [63:0] x, input logic [63:0] y, input bit sm, output bit ok);
    logic [131:0] e;
    @(negedge clk);
    b2.start = st;
    b2.out_ready = ordy;
    b2.a_mat = x;
    b2.b_mat = y;
    b2.signed_mode = sm;
    #1;
    cyc++;
    if (stall_prev) chk("hold_c", b2.c_mat, held);
    if (b2.done && ordy) begin
      chk("q_nonempty", 132'(expq.size() != 0), 132'(1));
      if (expq.size() != 0) begin
        e = expq.pop_front();
        for (int q = 0; q < 4; q++) chk($sformatf("res%0d_c%0d", got_n, q), 132'(b2.c_mat[q*33 +: 33]), 132'(e[q*33 +: 33]));
      end
      got_n++;
      if (got_n == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    stall_prev = b2.done && !ordy;
    held = b2.c_mat;
    if (stall_prev) begin
      n_stall++;
      chk("in_ready_low", 132'(b2.in_ready), 132'(0));
    end
    ok = st && b2.in_ready;
    if (ok) expq.push_back(mm2(x, y, sm));
  endtask
  task automatic clr();
    cyc = 0; got_n = 0; first_cyc = 0; last_cyc = 0; n_stall = 0; n_acc = 0; stall_prev = 0;
    expq.delete();
  endtask
  initial begin
    reset = 1'b0;
    b2.start = 0; b2.out_ready = 1; b2.signed_mode = 1; b2.a_mat = '0; b2.b_mat = '0;
    b3.start = 0; b3.out_ready = 1; b3.signed_mode = 0; b3.a_mat = '0; b3.b_mat = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", 132'(b2.done), 132'(0));
    chk("rst_c", 132'(b2.c_mat), 132'(0));
    chk("rst_in_ready", 132'(b2.in_ready), 132'(1));
    chk("rst_done3", 132'(b3.done), 132'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    b2.start = 1; b2.signed_mode = 1; b2.a_mat = pk(1, 2, 3, 4); b2.b_mat = pk(5, 6, 7, 8);
    @(negedge clk);
    b2.start = 0;
    #1 chk("lat1_done", 132'(b2.done), 132'(0));
    @(negedge clk);
    #1 chk("lat2_done", 132'(b2.done), 132'(0));
    @(negedge clk);
    #1 chk("lat3_done", 132'(b2.done), 132'(1));
    chk_c("basic", 19, 22, 43, 50);
    @(negedge clk);
    #1 chk("after_done", 132'(b2.done), 132'(0));
    chk_c("retain", 19, 22, 43, 50);
    @(negedge clk);
    b2.start = 1; b2.signed_mode = 1; b2.a_mat = {4{16'h8000}}; b2.b_mat = {4{16'h8000}};
    @(negedge clk);
    b2.signed_mode = 0;
    @(negedge clk);
    b2.a_mat = {4{16'hFFFF}}; b2.b_mat = {4{16'hFFFF}};
    @(negedge clk);
    b2.start = 0;
    #1 chk("ext_s_done", 132'(b2.done), 132'(1));
    chk_c("ext_s", 64'h0_8000_0000, 64'h0_8000_0000, 64'h0_8000_0000, 64'h0_8000_0000);
    @(negedge clk);
    #1 chk_c("ext_u", 64'h0_8000_0000, 64'h0_8000_0000, 64'h0_8000_0000, 64'h0_8000_0000);
    @(negedge clk);
    #1 chk_c("ext_ff", 64'h1_FFFC_0002, 64'h1_FFFC_0002, 64'h1_FFFC_0002, 64'h1_FFFC_0002);
    clr();
    for (int t = 0; t < 100; t++) begin
      for (int q = 0; q < 4; q++) begin
        a[q*16 +: 16] = 16'(int'($urandom_range(40)) - 20);
        b[q*16 +: 16] = 16'(int'($urandom_range(40)) - 20);
      end
      step(1, 1, a, b, 1, acc);
      if (acc) n_acc++;
    end
    repeat (6) step(0, 1, a, b, 1, acc);
    chk("stream_acc", 132'(n_acc), 132'(100));
    chk("stream_got", 132'(got_n), 132'(100));
    chk("stream_consec", 132'(last_cyc - first_cyc + 1), 132'(100));
    chk("stream_q_empty", 132'(expq.size()), 132'(0));
    clr();
    for (int k = 0; k < 60 && n_acc < 10; k++) begin
      for (int q = 0; q < 4; q++) begin
        a[q*16 +: 16] = 16'(int'($urandom_range(40)) - 20 + n_acc);
        b[q*16 +: 16] = 16'(int'($urandom_range(40)) - 20);
      end
      step(1, !(k >= 5 && k <= 8), a, b, n_acc[0], acc);
      if (acc) n_acc++;
    end
    repeat (6) step(0, 1, a, b, 1, acc);
    chk("bp_acc", 132'(n_acc), 132'(10));
    chk("bp_stalls", 132'(n_stall), 132'(4));
    chk("bp_got", 132'(got_n), 132'(10));
    chk("bp_q_empty", 132'(expq.size()), 132'(0));
    clr();
    repeat (3) step(1, 1, pk(3, 1, 4, 1), pk(5, 9, 2, 6), 1, acc);
    @(negedge clk);
    b2.start = 0;
    reset = 1'b0;
    #1;
    chk("mid_rst_done", 132'(b2.done), 132'(0));
    chk("mid_rst_c", 132'(b2.c_mat), 132'(0));
    chk("mid_rst_in_ready", 132'(b2.in_ready), 132'(1));
    expq.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    b2.start = 1; b2.signed_mode = 1; b2.a_mat = pk(1, 0, 0, 1); b2.b_mat = pk(9, 8, 7, 6);
    @(negedge clk);
    b2.start = 0;
    #1 chk("post_rst_lat1", 132'(b2.done), 132'(0));
    @(negedge clk);
    #1 chk("post_rst_lat2", 132'(b2.done), 132'(0));
    @(negedge clk);
    #1 chk("post_rst_lat3", 132'(b2.done), 132'(1));
    chk_c("post_rst", 9, 8, 7, 6);
    @(negedge clk);
    b3.start = 1; b3.signed_mode = 0;
    b3.a_mat = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    b3.b_mat = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    @(negedge clk);
    b3.start = 0;
    repeat (2) @(negedge clk);
    #1 chk("n3_done", 132'(b3.done), 132'(1));
    for (int q = 0; q < 9; q++) chk($sformatf("n3_c%0d", q), 132'(b3.c_mat[q*18 +: 18]), 132'(q + 1));
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
